// File: rtl/exc_request_unit.sv
// Exception request initiator: synchronises IRQ/FIQ, masks against CPSR I/F, prioritises faults into a one-hot pulse.
// Optional build macro EXC_IRQ_LATCH_EN turns the IRQ request into a sticky pending bit set on a synchronised rising edge.
module exc_request_unit #(
  parameter int DRAIN_CYCLES = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRQpin,
  input  logic        FIQpin,
  input  logic [31:0] CPSRdata,
  input  logic        UndefE,
  input  logic        SWIE,
  input  logic        PrefetchAbortE,
  input  logic        DataAbortM,
  input  logic        StallE,
  output logic [5:0]  Exceptions,
  output logic        FlushExc,
  output logic        ExcBusy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  // Bus bit order {undef, swi, prefetch_abt, data_abt, irq, fiq}; priority da > fq > iq > pa > ud > sw.
  function automatic logic [5:0] prio_pick(input logic [5:0] cand);
    logic [5:0] win;
    win = 6'b0;
    if (cand[2])      win[2] = 1'b1;
    else if (cand[0]) win[0] = 1'b1;
    else if (cand[1]) win[1] = 1'b1;
    else if (cand[3]) win[3] = 1'b1;
    else if (cand[5]) win[5] = 1'b1;
    else if (cand[4]) win[4] = 1'b1;
    return win;
  endfunction

  logic [1:0]             state_q, state_d;
  logic [5:0]             exc_q, exc_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
  logic [SYNC_STAGES-1:0] fiq_sync_q, fiq_sync_d;

  logic       irq_s;
  logic       fiq_s;
  logic       irq_req;
  logic [5:0] cand;
  logic       unused_cpsr;

  assign unused_cpsr = ^{CPSRdata[31:8], CPSRdata[5:0]};

  always_comb begin
    irq_sync_d = {irq_sync_q[SYNC_STAGES-2:0], IRQpin};
    fiq_sync_d = {fiq_sync_q[SYNC_STAGES-2:0], FIQpin};
  end

  assign irq_s = irq_sync_q[SYNC_STAGES-1];
  assign fiq_s = fiq_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_sync_q <= '0;
      fiq_sync_q <= '0;
    end else begin
      irq_sync_q <= irq_sync_d;
      fiq_sync_q <= fiq_sync_d;
    end
  end

`ifdef EXC_IRQ_LATCH_EN
  logic irq_prev_q, irq_prev_d;
  logic irq_pend_q, irq_pend_d;

  // Set after clear so a rising edge coinciding with the issue is not lost.
  always_comb begin
    irq_prev_d = irq_s;
    irq_pend_d = irq_pend_q;
    if ((state_q == ISSUE) && exc_q[1]) irq_pend_d = 1'b0;
    if (irq_s && !irq_prev_q)           irq_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev_q <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_req = irq_pend_q;
`else
  assign irq_req = irq_s;
`endif

  always_comb begin
    cand    = 6'b0;
    cand[5] = UndefE & ~StallE;
    cand[4] = SWIE & ~StallE;
    cand[3] = PrefetchAbortE & ~StallE;
    cand[2] = DataAbortM;
    cand[1] = irq_req & ~CPSRdata[7];
    cand[0] = fiq_s & ~CPSRdata[6];
  end

  // Candidates are only looked at in IDLE; anything raised during ISSUE/DRAIN belongs to flushed work.
  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|cand) begin
          exc_d   = prio_pick(cand);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        exc_d   = 6'b0;
        cnt_d   = DRAIN_LOAD;
        state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = IDLE;
      end
      default: begin
        exc_d   = 6'b0;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      exc_q   <= 6'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    Exceptions = (state_q == ISSUE) ? exc_q : 6'b0;
    FlushExc   = (state_q == ISSUE) || (state_q == DRAIN);
    ExcBusy    = (state_q == ISSUE) || (state_q == DRAIN);
  end

endmodule

// File: tb/tb_exc_request_unit.sv
// Directed table-driven bench for exc_request_unit plus hand-written reset and IRQ-pulse sequences.
module tb_exc_request_unit;

  localparam logic [31:0] CP_MASK = 32'h0000_00D3;
  localparam logic [31:0] CP_FQ   = 32'h0000_0093;
  localparam logic [31:0] CP_IQ   = 32'h0000_0053;
  localparam logic [31:0] CP_NONE = 32'h0000_0013;

`ifdef EXC_IRQ_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        IRQpin, FIQpin;
  logic [31:0] CPSRdata;
  logic        UndefE, SWIE, PrefetchAbortE, DataAbortM, StallE;
  logic [5:0]  Exceptions;
  logic        FlushExc, ExcBusy;

  exc_request_unit #(.DRAIN_CYCLES(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .IRQpin(IRQpin), .FIQpin(FIQpin),
    .CPSRdata(CPSRdata), .UndefE(UndefE), .SWIE(SWIE),
    .PrefetchAbortE(PrefetchAbortE), .DataAbortM(DataAbortM), .StallE(StallE),
    .Exceptions(Exceptions), .FlushExc(FlushExc), .ExcBusy(ExcBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row: expected outputs seen at this negedge, then inputs driven for the following posedge.
  typedef struct {
    string       tag;
    logic [5:0]  e_exc;
    logic        e_fb;
    logic [1:0]  pins;   // {irq, fiq}
    logic [31:0] cpsr;
    logic [4:0]  ctl;    // {ud, sw, pa, da, stall}
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input string tag, input logic [5:0] e_exc, input logic e_fb,
                     input logic [1:0] pins, input logic [31:0] cpsr, input logic [4:0] ctl);
    vec_t v;
    v.tag = tag; v.e_exc = e_exc; v.e_fb = e_fb; v.pins = pins; v.cpsr = cpsr; v.ctl = ctl;
    vq.push_back(v);
  endtask

  task automatic add_drain(input string tag, input logic [1:0] pins, input logic [31:0] cpsr,
                           input logic [4:0] ctl);
    for (int k = 0; k < 3; k++) add(tag, 6'b0, 1'b1, pins, cpsr, ctl);
  endtask

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [5:0] e_exc, input logic e_fb);
    chk({name, ".exc"}, Exceptions, e_exc);
    chk({name, ".flush"}, {5'b0, FlushExc}, {5'b0, e_fb});
    chk({name, ".busy"}, {5'b0, ExcBusy}, {5'b0, e_fb});
  endtask

  task automatic drive(input logic [1:0] pins, input logic [31:0] cpsr, input logic [4:0] ctl);
    {IRQpin, FIQpin} = pins;
    CPSRdata = cpsr;
    {UndefE, SWIE, PrefetchAbortE, DataAbortM, StallE} = ctl;
  endtask

  initial begin
    reset = 1'b1;
    drive(2'b00, CP_MASK, 5'b00000);

    // Undef issued once, 1 cycle after candidate; held Undef ignored through drain.
    add("ud_idle",  6'b000000, 1'b0, 2'b00, CP_MASK, 5'b10000);
    add("ud_issue", 6'b100000, 1'b1, 2'b00, CP_MASK, 5'b10000);
    add_drain("ud_drain", 2'b00, CP_MASK, 5'b10000);
    add("ud_after", 6'b000000, 1'b0, 2'b00, CP_MASK, 5'b00000);
    add("ud_quiet", 6'b000000, 1'b0, 2'b00, CP_MASK, 5'b00000);
    // Stall blocks Execute faults for 5 cycles.
    for (int k = 0; k < 5; k++) add("st_hold", 6'b0, 1'b0, 2'b00, CP_MASK, 5'b10001);
    add("st_rel",   6'b000000, 1'b0, 2'b00, CP_MASK, 5'b10000);
    add("st_issue", 6'b100000, 1'b1, 2'b00, CP_MASK, 5'b00000);
    add_drain("st_drain", 2'b00, CP_MASK, 5'b00000);
    // Priority among synchronous faults.
    add("pr_idle1", 6'b000000, 1'b0, 2'b00, CP_MASK, 5'b11100);
    add("pr_pa",    6'b001000, 1'b1, 2'b00, CP_MASK, 5'b00000);
    add_drain("pr_dr1", 2'b00, CP_MASK, 5'b00000);
    add("pr_idle2", 6'b000000, 1'b0, 2'b00, CP_MASK, 5'b11000);
    add("pr_ud",    6'b100000, 1'b1, 2'b00, CP_MASK, 5'b00000);
    add_drain("pr_dr2", 2'b00, CP_MASK, 5'b00000);
    add("pr_idle3", 6'b000000, 1'b0, 2'b00, CP_MASK, 5'b01000);
    add("pr_sw",    6'b010000, 1'b1, 2'b00, CP_MASK, 5'b00000);
    add_drain("pr_dr3", 2'b00, CP_MASK, 5'b00000);
    add("pr_idle4", 6'b000000, 1'b0, 2'b00, CP_MASK, 5'b00111);
    add("pr_da",    6'b000100, 1'b1, 2'b00, CP_MASK, 5'b00000);
    add_drain("pr_dr4", 2'b00, CP_MASK, 5'b00000);
    // Data abort and synchronised FIQ together: abort first, FIQ after drain.
    add("fq_pin0",  6'b000000, 1'b0, 2'b01, CP_FQ, 5'b00000);
    add("fq_pin1",  6'b000000, 1'b0, 2'b01, CP_FQ, 5'b00000);
    add("fq_da",    6'b000000, 1'b0, 2'b01, CP_FQ, 5'b00010);
    add("fq_da_is", 6'b000100, 1'b1, 2'b01, CP_FQ, 5'b00000);
    add_drain("fq_dr1", 2'b01, CP_FQ, 5'b00000);
    add("fq_idle",  6'b000000, 1'b0, 2'b01, CP_FQ, 5'b00000);
    add("fq_issue", 6'b000001, 1'b1, 2'b00, CP_MASK, 5'b00000);
    add_drain("fq_dr2", 2'b00, CP_MASK, 5'b00000);
    // FIQ beats IRQ; IRQ follows once F is set and I is clear.
    add("fi_p0",    6'b000000, 1'b0, 2'b11, CP_NONE, 5'b00000);
    add("fi_p1",    6'b000000, 1'b0, 2'b11, CP_NONE, 5'b00000);
    add("fi_p2",    6'b000000, 1'b0, 2'b11, CP_NONE, 5'b00000);
    add("fi_fiq",   6'b000001, 1'b1, 2'b10, CP_IQ, 5'b00000);
    add_drain("fi_dr1", 2'b10, CP_IQ, 5'b00000);
    add("fi_idle",  6'b000000, 1'b0, 2'b10, CP_IQ, 5'b00000);
    add("fi_irq",   6'b000010, 1'b1, 2'b00, CP_MASK, 5'b00000);
    add_drain("fi_dr2", 2'b00, CP_MASK, 5'b00000);
    // IRQ held while I=1: nothing until I clears, then one cycle later.
    for (int k = 0; k < 5; k++) add("iq_mask", 6'b0, 1'b0, 2'b10, CP_MASK, 5'b00000);
    add("iq_unmask", 6'b000000, 1'b0, 2'b10, CP_IQ, 5'b00000);
    add("iq_issue",  6'b000010, 1'b1, 2'b00, CP_MASK, 5'b00000);
    add_drain("iq_drain", 2'b00, CP_MASK, 5'b00000);
    add("iq_done",   6'b000000, 1'b0, 2'b00, CP_MASK, 5'b00000);

    #1 chk_all("reset_state", 6'b0, 1'b0);
    @(negedge clk);
    chk_all("reset_hold", 6'b0, 1'b0);
    reset = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      chk_all(vq[i].tag, vq[i].e_exc, vq[i].e_fb);
      drive(vq[i].pins, vq[i].cpsr, vq[i].ctl);
    end

    // One-cycle IRQ pulse while masked; I cleared 10 cycles later.
    @(negedge clk);
    drive(2'b10, CP_MASK, 5'b00000);
    @(negedge clk);
    drive(2'b00, CP_MASK, 5'b00000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_all("pulse_wait", 6'b0, 1'b0);
    end
    CPSRdata = CP_IQ;
    @(negedge clk);
    chk_all("pulse_issue", LATCH ? 6'b000010 : 6'b000000, LATCH);
    CPSRdata = CP_MASK;
    @(negedge clk);
    chk_all("pulse_next", 6'b0, LATCH);
    for (int k = 0; k < 4; k++) @(negedge clk);
    CPSRdata = CP_IQ;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_all("pulse_once", 6'b0, 1'b0);
    end
    CPSRdata = CP_MASK;

    // Reset arriving mid-DRAIN with the counter at 2.
    @(negedge clk);
    SWIE = 1'b1;
    @(negedge clk);
    chk_all("rst_issue", 6'b010000, 1'b1);
    SWIE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all("rst_pre", 6'b0, 1'b1);
    #1 reset = 1'b1;
    #1 chk_all("rst_async", 6'b0, 1'b0);
    @(negedge clk);
    chk_all("rst_held", 6'b0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_all("rst_after", 6'b0, 1'b0);
    end
    UndefE = 1'b1;
    @(negedge clk);
    UndefE = 1'b0;
    chk_all("rst_resume", 6'b100000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_request_unit.md
Name: exc_request_unit

Overview:
- Initiator side of the 6-bit exception request bus consumed by the processor status/mode block.
- Collects synchronous faults from the pipeline (undefined, SWI, prefetch abort, data abort) and asynchronous IRQ/FIQ pins.
- Synchronises and masks the pins against the current I/F bits, then prioritises everything into a single one-cycle one-hot request.
- Holds the pipeline in a flush/drain window so a flushed instruction cannot raise a second request.

Parameters:
- DRAIN_CYCLES, 3, cycles after an issue during which new requests are suppressed and FlushExc stays high (legal range 1..15)
- SYNC_STAGES, 2, flip-flop depth of the IRQ/FIQ pin synchronisers (legal range 2..4)

Ports:
- clk  input  1  core clock; all state changes on posedge
- reset  input  1  asynchronous, active-high reset
- IRQpin  input  1  external interrupt request, asynchronous, level, active-high
- FIQpin  input  1  external fast interrupt request, asynchronous, level, active-high
- CPSRdata  input  32  current status word; bit7=I (IRQ mask), bit6=F (FIQ mask)
- UndefE  input  1  undefined instruction in Execute
- SWIE  input  1  SWI instruction in Execute
- PrefetchAbortE  input  1  instruction in Execute carries a prefetch abort
- DataAbortM  input  1  data abort reported by the Memory stage
- StallE  input  1  Execute stalled; synchronous Execute faults are not accepted
- Exceptions  output  6  request bus {undef, swi, prefetch_abt, data_abt, irq, fiq}, one-hot or zero
- FlushExc  output  1  flush pipeline stages younger than the faulting point
- ExcBusy  output  1  high while in ISSUE or DRAIN

Behaviour:
- Reset is asynchronous. It immediately forces state IDLE, Exceptions=0, FlushExc=0, ExcBusy=0, drain counter=0, all synchroniser flops=0 and the pending IRQ bit=0. This holds even if reset arrives mid-ISSUE or mid-DRAIN.
- Synchronisers: irq_s and fiq_s are IRQpin/FIQpin delayed SYNC_STAGES flops. The first sample reaches candidate logic SYNC_STAGES cycles after the pin rises.
- Candidates (combinational from registered and input state):
  - da = DataAbortM
  - fq = fiq_s & ~CPSRdata[6]
  - iq = irq_req & ~CPSRdata[7]
  - pa = PrefetchAbortE & ~StallE
  - ud = UndefE & ~StallE
  - sw = SWIE & ~StallE
- Priority, highest first: da > fq > iq > pa > ud > sw. Exactly one winner is chosen. All losers are dropped, except IRQ/FIQ, which remain requested while their level (or pending bit) persists.
- States:
  - IDLE: Exceptions=0, FlushExc=0. If any candidate is true, register the one-hot winner and go to ISSUE next cycle. Request latency is 1 cycle from candidate to Exceptions.
  - ISSUE: exactly one cycle. Exceptions=registered winner, FlushExc=1, ExcBusy=1. Load counter=DRAIN_CYCLES, go to DRAIN.
  - DRAIN: Exceptions=0, FlushExc=1, ExcBusy=1. Counter decrements each cycle. All candidates are ignored, including DataAbortM, because it belongs to flushed work. When counter reaches 1, go to IDLE on the next edge.
- A pin still high when DRAIN ends is re-evaluated in IDLE against the updated I/F bits. The status block sets I on entry, so a held IRQ is not re-issued until I clears.
- Mask change and pin assertion in the same cycle: the mask value sampled that cycle decides.
- Simultaneous DataAbortM and FIQ in IDLE: data abort is issued; FIQ is issued after DRAIN if F is still clear.
- Exceptions is never multi-hot and never asserted for two consecutive cycles.

Optional Feature:
- Macro: EXC_IRQ_LATCH_EN
- Defined: irq_req is a sticky pending bit.
  - Set on a rising edge of irq_s.
  - Cleared in the cycle IRQ is issued (ISSUE with irq winner).
  - A pulse shorter than the mask window is therefore remembered until I clears.
  - A new rising edge that coincides with the clear sets the bit again (set wins).
- Undefined: irq_req = irq_s. IRQ is level-sensitive and is lost if the pin drops before it is unmasked.

Test Plan:
- Reset during DRAIN (counter=2) -> Exceptions=0, FlushExc=0, ExcBusy=0 within the same cycle; IDLE after release, no spurious issue.
- UndefE=1, StallE=0, CPSRdata=0x000000D3 -> Exceptions=6'b100000 for exactly one cycle, 1 cycle later; FlushExc high for 1+3 cycles; UndefE held high during DRAIN is not reissued.
- DataAbortM=1 and FIQpin high (synchronised) in the same IDLE cycle, F=0 -> 6'b000100 first; after DRAIN completes, 6'b000001.
- IRQpin high, CPSRdata[7]=1 -> no request; clear bit7 -> 6'b000010 one cycle later.
- UndefE=1 with StallE=1 for 5 cycles -> no request; StallE drops -> 6'b100000.
- EXC_IRQ_LATCH_EN defined: 1-cycle IRQpin pulse while I=1, I cleared 10 cycles later -> 6'b000010 issued once. Undefined build: same stimulus -> no request.
